div_sequencer: RTL and testbench
================================

Name: div_sequencer

Overview:
Multi-cycle integer divide controller for the EX stage. It accepts one div.w/div.wu/mod.w/mod.wu operation through a valid/ready handshake and runs a restoring radix-2 divide, one quotient bit per cycle. It returns the selected quotient or remainder through a second valid/ready handshake. EX holds the instruction while `busy` is high; a pipeline flush aborts the operation in flight.

Parameters:
WIDTH, 32, operand/result width; iteration count equals WIDTH.

Ports:
clk  in  1  clock
resetn  in  1  reset
req_valid  in  1  EX presents a divide op
req_ready  out  1  sequencer can accept
op_signed  in  1  1 = div.w/mod.w, 0 = div.wu/mod.wu
op_mod  in  1  1 = return remainder, 0 = return quotient
src1  in  WIDTH  dividend
src2  in  WIDTH  divisor
flush  in  1  abort current op (branch/exception cancel)
resp_valid  out  1  result available
resp_ready  in  1  EX consumes result
result  out  WIDTH  quotient or remainder
busy  out  1  high in CALC or DONE

Behaviour:
- Reset: resetn is synchronous and active-low; clock is clk.
  - Outputs while in reset and on the first cycle after: state IDLE, req_ready=0 while resetn low, resp_valid=0, busy=0, result=0.
  - All internal registers (counter, partial remainder, quotient, sign flags) are cleared to 0.
- States: IDLE, CALC, DONE.
- req_ready = (state==IDLE) & resetn & ~flush.
- Accept: req_valid & req_ready at a rising edge (E0).
  - Latch op_signed, op_mod.
  - Latch sign flags: sq = signed & (src1[MSB] ^ src2[MSB]); sr = signed & src1[MSB].
  - Latch |src1| and |src2|; the magnitude is the two's complement if signed and MSB set, otherwise the raw value, held WIDTH bits unsigned.
  - Clear counter and partial remainder.
  - If src2==0: go to DONE with quotient=all ones and remainder=src1 (raw, no sign fixup).
  - Otherwise go to CALC.
- CALC: each edge performs one step.
  - Shift {rem, dvd} left 1; trial = rem - divisor, computed WIDTH+1 bits wide.
  - If non-negative: rem=trial, quotient bit=1; else quotient bit=0.
  - counter++.
  - On the edge where counter==WIDTH-1, go to DONE and apply sign fixup: quotient negated if sq, remainder negated if sr. Store both in registers.
- Latency: resp_valid first high after edge E0+WIDTH, i.e. 32 edges after accept. For divide-by-zero it is high after edge E0+1.
- DONE: resp_valid=1; result = op_mod ? remainder : quotient. The result is held stable until resp_valid & resp_ready, then IDLE on that edge.
- No same-edge accept while in DONE; the earliest next accept is the edge after the return to IDLE.
- Signed overflow (0x80000000 / 0xFFFFFFFF signed): quotient=0x80000000 (wraps), remainder=0. The natural algorithm produces this; no special case.
- flush: synchronous, highest priority after reset.
  - From any state, go to IDLE at the next edge; resp_valid and busy drop after that edge.
  - The result is discarded; a response completing in the same cycle as flush is not delivered.
  - req_valid in the same cycle as flush is not accepted.
- resetn low mid-operation: abort to IDLE; registers cleared as at reset.
- req_valid deasserted after accept has no effect; operands are already latched.

Test Plan:
1. Unsigned quotient/remainder: unsigned, op_mod=0, src1=100, src2=7 → resp_valid 32 edges after accept, result=14, busy=1 throughout. Repeat with op_mod=1 → result=2.
2. Signed, negative dividend: signed, src1=0xFFFFFFF9 (-7), src2=2 → div result=0xFFFFFFFD (-3); mod result=0xFFFFFFFF (-1).
3. Signed, negative divisor: signed, src1=7, src2=0xFFFFFFFE (-2) → div result=0xFFFFFFFD; mod result=1.
4. Divide by zero and overflow:
   - src1=0x00001234, src2=0 → resp_valid after 1 edge; div result=0xFFFFFFFF, mod result=0x00001234.
   - Signed 0x80000000/0xFFFFFFFF → div result=0x80000000, mod result=0.
5. Backpressure: hold resp_ready=0 for 5 cycles in DONE → resp_valid and result unchanged, req_ready=0. Assert resp_ready → IDLE next edge, req_ready=1.
6. Flush and reset mid-operation:
   - flush on the 10th CALC cycle → IDLE next edge, resp_valid never asserts. A following request 50/5 completes with result=10.
   - resetn low during CALC → all outputs 0; the next op completes correctly.

Source files
------------

// File: rtl/div_sequencer.sv
// Multi-cycle restoring radix-2 integer divide sequencer for the EX stage.
// One op in via req handshake, quotient or remainder out via resp handshake.
module div_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             op_signed,
  input  logic             op_mod,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  input  logic             flush,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] result,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
  localparam logic [WIDTH-1:0] ZERO     = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONES     = {WIDTH{1'b1}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] rem_r;
  logic [WIDTH-1:0] dvd_r;
  logic [WIDTH-1:0] dvs_r;
  logic [WIDTH-1:0] result_r;
  logic             sq_r;
  logic             sr_r;
  logic             op_mod_r;
  logic             dz_r;

  logic [WIDTH:0]   shifted_s;
  logic [WIDTH:0]   trial_s;
  logic             q_bit_s;
  logic [WIDTH-1:0] rem_next_s;
  logic [WIDTH-1:0] quo_next_s;
  logic [WIDTH-1:0] rem_fix_s;
  logic [WIDTH-1:0] quo_fix_s;
  logic [WIDTH-1:0] abs1_s;
  logic [WIDTH-1:0] abs2_s;

  function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v, input logic en);
    return en ? (~v + ONE) : v;
  endfunction

  assign req_ready  = (state_r == IDLE) & resetn & ~flush;
  assign resp_valid = (state_r == DONE);
  assign busy       = (state_r != IDLE);
  assign result     = result_r;

  // One restoring step plus operand magnitudes and final sign fixup.
  always_comb begin
    shifted_s = {rem_r, dvd_r[WIDTH-1]};
    trial_s   = shifted_s - {1'b0, dvs_r};
    if (!trial_s[WIDTH]) begin
      q_bit_s    = 1'b1;
      rem_next_s = trial_s[WIDTH-1:0];
    end else begin
      q_bit_s    = 1'b0;
      rem_next_s = shifted_s[WIDTH-1:0];
    end
    quo_next_s = {dvd_r[WIDTH-2:0], q_bit_s};
    quo_fix_s  = neg_if(quo_next_s, sq_r);
    rem_fix_s  = neg_if(rem_next_s, sr_r);
    abs1_s     = neg_if(src1, op_signed & src1[WIDTH-1]);
    abs2_s     = neg_if(src2, op_signed & src2[WIDTH-1]);
  end

  // Control FSM and datapath registers; divide-by-zero spends one CALC cycle.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_r  <= IDLE;
      cnt_r    <= {CW{1'b0}};
      rem_r    <= ZERO;
      dvd_r    <= ZERO;
      dvs_r    <= ZERO;
      result_r <= ZERO;
      sq_r     <= 1'b0;
      sr_r     <= 1'b0;
      op_mod_r <= 1'b0;
      dz_r     <= 1'b0;
    end else if (flush) begin
      state_r  <= IDLE;
      result_r <= ZERO;
    end else begin
      case (state_r)
        IDLE: begin
          if (req_valid) begin
            op_mod_r <= op_mod;
            sq_r     <= op_signed & (src1[WIDTH-1] ^ src2[WIDTH-1]);
            sr_r     <= op_signed & src1[WIDTH-1];
            cnt_r    <= {CW{1'b0}};
            dvs_r    <= abs2_s;
            state_r  <= CALC;
            if (src2 == ZERO) begin
              dz_r  <= 1'b1;
              rem_r <= src1;
              dvd_r <= ONES;
            end else begin
              dz_r  <= 1'b0;
              rem_r <= ZERO;
              dvd_r <= abs1_s;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        CALC: begin
          if (dz_r) begin
            state_r  <= DONE;
            result_r <= op_mod_r ? rem_r : dvd_r;
          end else if (cnt_r == CNT_LAST) begin
            state_r  <= DONE;
            cnt_r    <= cnt_r + CNT_ONE;
            rem_r    <= rem_fix_s;
            dvd_r    <= quo_fix_s;
            result_r <= op_mod_r ? rem_fix_s : quo_fix_s;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
            rem_r <= rem_next_s;
            dvd_r <= quo_next_s;
          end
        end
        DONE: begin
          if (resp_ready) begin
            state_r  <= IDLE;
            result_r <= ZERO;
          end else begin
            state_r <= DONE;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_sequencer.sv
// Self-checking bench for div_sequencer: directed cases plus random ops
// compared against a plain-arithmetic reference model.
module tb_div_sequencer;

  logic        clk = 1'b0;
  logic        resetn;
  logic        req_valid;
  logic        req_ready;
  logic        op_signed;
  logic        op_mod;
  logic [31:0] src1;
  logic [31:0] src2;
  logic        flush;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] result;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  div_sequencer #(.WIDTH(32)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .op_signed  (op_signed),
    .op_mod     (op_mod),
    .src1       (src1),
    .src2       (src2),
    .flush      (flush),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .result     (result),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model(input logic sg, input logic md,
                                        input logic [31:0] a, input logic [31:0] b);
    longint sa;
    longint sb;
    longint q;
    longint r;
    if (b == 32'd0) return md ? a : 32'hFFFF_FFFF;
    sa = sg ? longint'($signed(a)) : longint'(a);
    sb = sg ? longint'($signed(b)) : longint'(b);
    q  = sa / sb;
    r  = sa % sb;
    return md ? r[31:0] : q[31:0];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Issue one op, check latency, busy, result, backpressure hold and return to IDLE.
  task automatic run_op(input logic sg, input logic md, input logic [31:0] a,
                        input logic [31:0] b, input int stall);
    logic [31:0] exp;
    int          lat;
    logic        busy_ok;
    exp = model(sg, md, a, b);
    @(negedge clk);
    req_valid = 1'b1; op_signed = sg; op_mod = md; src1 = a; src2 = b; resp_ready = 1'b0;
    check("req_ready_idle", {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0; src1 = $urandom; src2 = $urandom;
    lat = 0;
    busy_ok = 1'b1;
    while (!resp_valid && lat < 100) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    check("latency", lat, (b == 32'd0) ? 32'd1 : 32'd32);
    check("busy_calc", {31'd0, busy_ok}, 32'd1);
    check("result", result, exp);
    check("req_ready_done", {31'd0, req_ready}, 32'd0);
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      check("hold_valid", {31'd0, resp_valid}, 32'd1);
      check("hold_result", result, exp);
    end
    @(negedge clk); resp_ready = 1'b1;
    @(posedge clk); #1; resp_ready = 1'b0;
    check("ret_valid", {31'd0, resp_valid}, 32'd0);
    check("ret_busy", {31'd0, busy}, 32'd0);
    check("ret_ready", {31'd0, req_ready}, 32'd1);
  endtask

  task automatic accept_only(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    req_valid = 1'b1; op_signed = 1'b0; op_mod = 1'b0; src1 = a; src2 = b;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  initial begin
    logic seen;
    logic [31:0] ra;
    logic [31:0] rb;
    resetn = 1'b0; req_valid = 1'b0; op_signed = 1'b0; op_mod = 1'b0;
    src1 = 32'd0; src2 = 32'd0; flush = 1'b0; resp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", {31'd0, req_ready}, 32'd0);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_result", result, 32'd0);
    @(negedge clk); resetn = 1'b1;
    @(posedge clk); #1;
    check("post_rst_busy", {31'd0, busy}, 32'd0);
    check("post_rst_valid", {31'd0, resp_valid}, 32'd0);

    run_op(1'b0, 1'b0, 32'd100, 32'd7, 0);
    run_op(1'b0, 1'b1, 32'd100, 32'd7, 0);
    run_op(1'b1, 1'b0, 32'hFFFF_FFF9, 32'd2, 0);
    run_op(1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, 0);
    run_op(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFE, 0);
    run_op(1'b1, 1'b1, 32'd7, 32'hFFFF_FFFE, 0);
    run_op(1'b0, 1'b0, 32'h0000_1234, 32'd0, 0);
    run_op(1'b1, 1'b1, 32'h0000_1234, 32'd0, 0);
    run_op(1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, 5);

    // Flush on the 10th CALC cycle with a competing request.
    accept_only(32'd100, 32'd7);
    repeat (9) @(posedge clk);
    @(negedge clk); flush = 1'b1; req_valid = 1'b1;
    check("flush_req_ready", {31'd0, req_ready}, 32'd0);
    @(posedge clk); #1; flush = 1'b0; req_valid = 1'b0;
    check("flush_busy", {31'd0, busy}, 32'd0);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (resp_valid === 1'b1 || busy === 1'b1) seen = 1'b1;
    end
    check("flush_no_resp", {31'd0, seen}, 32'd0);
    run_op(1'b0, 1'b0, 32'd50, 32'd5, 0);

    // Reset in the middle of CALC.
    accept_only(32'd1000, 32'd3);
    repeat (5) @(posedge clk);
    @(negedge clk); resetn = 1'b0;
    @(posedge clk); #1;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_valid", {31'd0, resp_valid}, 32'd0);
    check("midrst_ready", {31'd0, req_ready}, 32'd0);
    check("midrst_result", result, 32'd0);
    @(negedge clk); resetn = 1'b1;
    run_op(1'b0, 1'b1, 32'd1000, 32'd3, 0);

    for (int k = 0; k < 24; k++) begin
      ra = $urandom;
      case ($urandom_range(3, 0))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(15, 1));
        2:       rb = ~32'($urandom_range(15, 0));
        default: rb = $urandom;
      endcase
      run_op(1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), ra, rb,
             int'($urandom_range(2, 0)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
